// File: rtl/conv2d_stream_kxk.sv
// Streaming KxK "valid" 2-D convolution with valid/ready backpressure, frame markers,
// rounding and saturation to the pixel range.
// Optional feature macro: CONV_ABS_EN (negative results become their magnitude instead of 0).
// Reset rstn is asynchronous and active-high.
module conv2d_stream_kxk #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned K      = 3,
  parameter int unsigned IMG_W  = 64,
  parameter int unsigned IMG_H  = 64,
  parameter int unsigned SHIFT  = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sof,
  input  logic [PIX_W-1:0]           in_px,
  input  logic                       kernel_wr,
  input  logic [$clog2(K*K)-1:0]     kernel_addr,
  input  logic [COEF_W-1:0]          kernel_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sof,
  output logic                       out_eol,
  output logic [PIX_W-1:0]           out_px
);

  localparam int unsigned NTap   = K * K;
  localparam int unsigned Center = NTap / 2;
  localparam int unsigned XW     = $clog2(IMG_W);
  localparam int unsigned YW     = $clog2(IMG_H);
  localparam logic signed [COEF_W-1:0] Ident  = COEF_W'(1) << SHIFT;
  localparam logic signed [ACC_W-1:0]  Rnd    = (SHIFT > 0) ? (ACC_W'(1) << (SHIFT - 1)) : '0;
  localparam logic signed [ACC_W-1:0]  PixMax = {{(ACC_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  logic                     adv, accept, win_done;
  logic [XW-1:0]            x_q, x_d, cur_x;
  logic [YW-1:0]            y_q, y_d, cur_y;
  logic [PIX_W-1:0]         lb_q  [K-1][IMG_W];
  logic [PIX_W-1:0]         col   [K];
  logic [PIX_W-1:0]         win_q [NTap];
  logic signed [COEF_W-1:0] coef_q [NTap];
  logic signed [ACC_W-1:0]  prod_d [NTap];
  logic signed [ACC_W-1:0]  prod_q [NTap];
  logic signed [ACC_W-1:0]  sum, scaled, mag;
  logic [PIX_W-1:0]         px_d;
  logic                     s1_valid, s1_sof, s1_eol;
  logic                     s2_valid, s2_sof, s2_eol;

  // Whole pipeline moves together; a stalled output register freezes everything upstream.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign accept   = in_valid & adv;

  // A frame-start pixel is always position (0,0) regardless of the counters.
  assign cur_x    = in_sof ? '0 : x_q;
  assign cur_y    = in_sof ? '0 : y_q;
  assign win_done = (cur_x >= XW'(K - 1)) && (cur_y >= YW'(K - 1));

  // Raster position of the next pixel.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (cur_x == XW'(IMG_W - 1)) begin
        x_d = '0;
        y_d = (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + YW'(1);
      end else begin
        x_d = cur_x + XW'(1);
        y_d = cur_y;
      end
    end
  end

  // Position counters.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // New window column: line buffers hold older rows, in_px is the bottom row.
  always_comb begin
    for (int r = 0; r < K; r++) col[r] = '0;
    col[K-1] = in_px;
    for (int r = 0; r < K - 1; r++) col[r] = lb_q[K-2-r][cur_x];
  end

  // Line buffers, window shift register and products; contents masked by valids, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_q[0][cur_x] <= in_px;
      for (int j = 1; j < K - 1; j++) lb_q[j][cur_x] <= lb_q[j-1][cur_x];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          if (c < K - 1) win_q[r*K+c] <= win_q[r*K+c+1];
          else           win_q[r*K+c] <= col[r];
        end
      end
    end
    if (adv) begin
      for (int i = 0; i < NTap; i++) prod_q[i] <= prod_d[i];
    end
  end

  // Signed coefficient times zero-extended pixel.
  always_comb begin
    for (int i = 0; i < NTap; i++) begin
      prod_d[i] = $signed({{(ACC_W-COEF_W){coef_q[i][COEF_W-1]}}, coef_q[i]})
                * $signed({{(ACC_W-PIX_W){1'b0}}, win_q[i]});
    end
  end

  // Adder tree, round-half-up, shift and clamp to the pixel range.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NTap; i++) sum = sum + prod_q[i];
    scaled = (sum + Rnd) >>> SHIFT;
`ifdef CONV_ABS_EN
    mag = scaled[ACC_W-1] ? -scaled : scaled;
`else
    mag = scaled[ACC_W-1] ? '0 : scaled;
`endif
    // Negating the most negative value wraps negative; saturate that too.
    px_d = (mag[ACC_W-1] || (mag > PixMax)) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
  end

  // Coefficient registers, identity kernel at reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < NTap; i++) coef_q[i] <= (i == Center) ? Ident : '0;
    end else if (kernel_wr && (32'(kernel_addr) < NTap)) begin
      coef_q[kernel_addr] <= kernel_data;
    end
  end

  // Pipeline valids, markers and output register.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      s1_valid  <= 1'b0;
      s1_sof    <= 1'b0;
      s1_eol    <= 1'b0;
      s2_valid  <= 1'b0;
      s2_sof    <= 1'b0;
      s2_eol    <= 1'b0;
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      out_px    <= '0;
    end else if (adv) begin
      s1_valid  <= accept & win_done;
      s1_sof    <= (cur_x == XW'(K - 1)) && (cur_y == YW'(K - 1));
      s1_eol    <= (cur_x == XW'(IMG_W - 1));
      s2_valid  <= s1_valid;
      s2_sof    <= s1_sof;
      s2_eol    <= s1_eol;
      out_valid <= s2_valid;
      out_sof   <= s2_valid & s2_sof;
      out_eol   <= s2_valid & s2_eol;
      if (s2_valid) out_px <= px_d;
    end
  end

endmodule

// File: doc/conv2d_stream_kxk.md
# conv2d_stream_kxk

Streaming K×K 2-D convolution engine, generalising the fixed 3×3 stream convolver to any odd kernel size. It adds valid/ready backpressure, frame markers, rounding and saturation to pixel range. It accepts one raster-order pixel per accepted cycle and produces one filtered pixel per full-window position ("valid" convolution, no padding). It sits between the pixel source (DMA/stream adapter) and the output sink in the image pipeline; coefficients are loaded through a simple write port from the CSR bridge.

## Interface
- PIX_W, 8, unsigned pixel width (in and out)
- COEF_W, 16, signed coefficient width
- ACC_W, 32, signed accumulator width; must hold K*K*(2^PIX_W-1)*2^(COEF_W-1)
- K, 3, kernel size; odd, 3..7
- IMG_W, 64, frame width in pixels (≥K)
- IMG_H, 64, frame height in lines (≥K)
- SHIFT, 8, right shift applied to accumulator (fixed-point scale)
- clk  in  1  clock
- rstn  in  1  reset; reset rstn, asynchronous, active-high; clock clk
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts pixel this cycle
- in_sof  in  1  accompanying pixel is frame start (x=0,y=0)
- in_px  in  PIX_W  input pixel, unsigned
- kernel_wr  in  1  coefficient write strobe
- kernel_addr  in  $clog2(K*K)  coefficient index, row-major (0 = top-left)
- kernel_data  in  COEF_W  signed coefficient
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts output
- out_sof  out  1  first output of frame
- out_eol  out  1  last output of a row
- out_px  out  PIX_W  filtered pixel

## Operation
- Global advance: adv = out_ready | ~out_valid; in_ready = adv. Accept = in_valid & in_ready.
- Position counters x (0..IMG_W-1), y (0..IMG_H-1) advance on accept; x wraps to 0 with y+1; y wraps to 0 after (IMG_W-1, IMG_H-1). An accepted pixel with in_sof=1 is treated as (0,0), and counters restart from it.
- K-1 line buffers of IMG_W×PIX_W are written at column x on accept. A K×K window shift register is updated on accept.
- Window is complete when x ≥ K-1 and y ≥ K-1; only complete windows enter the pipeline. Output frame is (IMG_W-K+1)×(IMG_H-K+1).
- Arithmetic: acc = Σ coef[i]·pix[i] (pix zero-extended, signed, ACC_W). If SHIFT>0, add 2^(SHIFT-1) and then arithmetic shift right by SHIFT. Clamp to [0, 2^PIX_W-1] (see Configuration for negatives).
- out_sof=1 for window at (K-1,K-1); out_eol=1 for x=IMG_W-1.
- Coefficients are registered. Reset value is identity: coef[(K*K)/2] = 2^SHIFT, all others 0. A write takes effect at the next edge. kernel_addr ≥ K*K is ignored. Mid-frame writes are legal but affect subsequent products only.

## Timing
- Pipeline of 3 stages: S1 window capture (accept edge), S2 registered products, S3 adder tree + round + clamp into output register. All stages hold when adv=0.
- Latency: the accept edge of a window's bottom-right pixel to out_valid=1 is 2 cycles with out_ready held high.
- Throughput is 1 pixel/cycle with out_ready=1. With out_ready=0 and out_valid=1, in_ready=0, and out_px/out_sof/out_eol stay stable until accepted.
- Reset (async assert): out_valid=0, out_sof=0, out_eol=0, out_px=0, x=y=0, pipeline valids cleared, coefficients set to identity. Line-buffer contents are not reset (masked by counters).
- Reset mid-frame: the partial frame is discarded; the next accepted pixel is (0,0).
- A simultaneous kernel_wr and accept are both honoured.

## Configuration
- CONV_ABS_EN defined: negative post-shift results are replaced by their magnitude, then clamped high (edge-detection use).
- CONV_ABS_EN undefined: negative results clamp to 0.

## Test plan
- Reset defaults, K=3, IMG_W=8, IMG_H=6, ramp image px=y*8+x → 24 outputs, out_px equals the centre pixel (e.g. first = 9), out_sof on first, out_eol every 6th.
- All nine coefs = 32, constant image 80 → every output (9·80·32+128)>>8 = 90.
- All coefs = 256, constant image 200 → all outputs 255 (saturated).
- Centre coef = -256, others 0, image 50 → outputs 0 without CONV_ABS_EN, 50 with it.
- Random out_ready (low 5 consecutive cycles plus 30% random) → same 24 values in order as the no-stall run, in_ready low exactly when out_valid & ~out_ready.
- Assert rstn for 1 cycle after 20 pixels, then stream a full frame with in_sof → exactly 24 outputs, out_sof once, coefficients back to identity.
